bin_ascii_streamer: RTL

//   Sequential, parametrised binary-to-ASCII text serializer for debug output.

---
 rtl/bin_ascii_streamer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/bin_ascii_streamer.sv
// Binary-to-ASCII text serializer: takes one WIDTH-bit word per handshake and
// streams it MSB first as binary or uppercase hex, with optional "0b"/"0x" prefix and CR LF.
module bin_ascii_streamer #(
    parameter int WIDTH     = 32,
    parameter int PREFIX_EN = 1,
    parameter int EOL_EN    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_char,
    output logic             out_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] BIN_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] HEX_LAST = CW'(WIDTH / 4 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PFX0,
        S_PFX1,
        S_DIGITS,
        S_CR,
        S_LF
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] data_q;
    logic             mode_q;
    logic [CW-1:0]    cnt_q;
    logic             accept;
    logic             advance;
    logic             load_cnt;
    logic             digit_mode;
    logic [3:0]       nibble;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    assign busy       = (state != S_IDLE);
    assign out_valid  = busy;
    assign in_ready   = (state == S_IDLE) && !rst;
    assign accept     = in_valid && in_ready;
    assign advance    = out_valid && out_ready;
    assign nibble     = data_q[WIDTH-1 -: 4];
    assign load_cnt   = (state != S_DIGITS) && (state_next == S_DIGITS);
    // Without a prefix the counter loads on the accept edge, before mode_q is valid.
    assign digit_mode = (state == S_IDLE) ? in_mode : mode_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_next = state;
        out_char   = 8'h00;
        out_last   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (accept) state_next = (PREFIX_EN != 0) ? S_PFX0 : S_DIGITS;
            end
            S_PFX0: begin
                out_char = 8'h30;
                if (out_ready) state_next = S_PFX1;
            end
            S_PFX1: begin
                out_char = mode_q ? 8'h78 : 8'h62;
                if (out_ready) state_next = S_DIGITS;
            end
            S_DIGITS: begin
                out_char = mode_q ? hex_char(nibble) : {7'b0011000, data_q[WIDTH-1]};
                out_last = (EOL_EN == 0) && (cnt_q == '0);
                if (out_ready && cnt_q == '0) state_next = (EOL_EN != 0) ? S_CR : S_IDLE;
            end
            S_CR: begin
                out_char = 8'h0D;
                if (out_ready) state_next = S_LF;
            end
            S_LF: begin
                out_char = 8'h0A;
                out_last = 1'b1;
                if (out_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: the word register is cleared on reset so an aborted frame leaves
    // no stale data behind; it is a handful of flops, not a memory array.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            mode_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (accept) begin
                data_q <= in_data;
                mode_q <= in_mode;
            end else if (state == S_DIGITS && advance) begin
                data_q <= mode_q ? (data_q << 4) : (data_q << 1);
            end

            if (load_cnt)
                cnt_q <= digit_mode ? HEX_LAST : BIN_LAST;
            else if (state == S_DIGITS && advance)
                cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule
